cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Parameters
REQ-001 The block SHALL have parameter N_SRC, default 3, giving the number of result sources (functional units or register bank) competing for the CDB, legal range 2..8.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the width of the broadcast data word.
REQ-003 The block SHALL have parameter TAG_W, default 3, giving the width of the reservation-station label (Qi) of the producer.
REQ-004 The block SHALL have parameter REG_W, default 3, giving the width of the destination register index.
REQ-005 The block SHALL have parameter RR_MODE, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority with index 0 highest.

Interface
REQ-006 Clock  in  1  sole clock; all state updates on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 req  in  N_SRC  per-source request; bit i high means source i holds a valid result.
REQ-009 tag_in  in  N_SRC*TAG_W  per-source producer label; slice i occupies bits [i*TAG_W +: TAG_W].
REQ-010 reg_in  in  N_SRC*REG_W  per-source destination register index, sliced as for tag_in.
REQ-011 data_in  in  N_SRC*DATA_W  per-source result data, sliced as for tag_in.
REQ-012 grant  out  N_SRC  combinational one-hot grant; all zero when no request is present or Reset is high.
REQ-013 cdb_valid  out  1  registered; high for one cycle per broadcast.
REQ-014 cdb_src  out  clog2(N_SRC)  registered index of the granted source.
REQ-015 cdb_tag, cdb_reg, cdb_data  out  TAG_W, REG_W, DATA_W  registered broadcast payload.

Function
REQ-016 The grant vector SHALL contain at most one bit set in every cycle.
REQ-017 In round-robin mode, the grant SHALL go to the first requesting index at or after pointer ptr, searching upward with wrap from N_SRC-1 to 0.
REQ-018 In fixed-priority mode, the grant SHALL go to the lowest requesting index, and ptr SHALL be ignored.
REQ-019 Handshake: a source SHALL hold req high with a stable payload until it samples grant[i]=1 at a rising edge; the transfer completes on that edge.
REQ-020 On an edge where grant[i]=1, the block SHALL register cdb_valid=1, cdb_src=i and payload slice i; the broadcast appears the cycle after grant, giving 1-cycle latency.
REQ-021 On an edge with no grant, the block SHALL register cdb_valid=0, and cdb_src, cdb_tag, cdb_reg and cdb_data SHALL hold their previous values.
REQ-022 ptr SHALL update to (i+1) mod N_SRC on every granted edge and hold otherwise; wrap from N_SRC-1 SHALL go to 0.
REQ-023 A source that drops req without being granted SHALL be ignored from that cycle, with no broadcast and no ptr change.
REQ-024 With all N_SRC sources requesting continuously in round-robin mode, each source SHALL be granted exactly once per N_SRC cycles.
REQ-025 The block SHALL sustain one broadcast per cycle, so back-to-back grants to different sources produce back-to-back cdb_valid pulses.
REQ-026 A source re-asserting req on the cycle after its grant SHALL be treated as a new request.
REQ-027 Data SHALL pass unmodified, with no arithmetic; tag value 0 is legal and is broadcast like any other value.

Reset
REQ-028 While Reset is high: grant=0, and on the edge cdb_valid<=0, cdb_src<=0, cdb_tag<=0, cdb_reg<=0, cdb_data<=0, ptr<=0.
REQ-029 A request pending when Reset asserts SHALL be dropped, with no broadcast; the source re-arbitrates after Reset deasserts.
REQ-030 On the first cycle after Reset deasserts, arbitration SHALL start from ptr=0.

Verification
REQ-031 Single request: after reset, req=3'b010, tag1=2, reg1=5, data1=16'h1234 -> grant=3'b010 same cycle; next cycle cdb_valid=1, src=1, tag=2, reg=5, data=16'h1234; ptr=2.
REQ-032 Round-robin fairness: req=3'b111 held for 6 cycles from ptr=0 -> grant order 0,1,2,0,1,2 with cdb_valid high for 6 consecutive cycles.
REQ-033 Fixed priority: RR_MODE=0, req=3'b110 held -> source 1 is granted every cycle and source 2 is never granted.
REQ-034 Wrap: ptr=2 with req=3'b011 -> grant=3'b001, then ptr=1 -> grant=3'b010.
REQ-035 Reset mid-transfer: req=3'b100 and Reset=1 in the same cycle -> grant=0 and cdb_valid=0 next cycle; after release, the grant goes to source 2 and the broadcast follows.
REQ-036 Idle hold: a broadcast of data 16'hBEEF followed by req=0 -> cdb_valid=0 and cdb_data stays 16'hBEEF.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Common data bus arbiter for a Tomasulo-style core. Several result sources
// (functional units, register bank) compete for one broadcast slot per cycle.
// A one-hot grant is produced combinationally from the current requests. The
// granted source's tag/register/data are captured onto the registered CDB
// outputs on the same clock edge, so the broadcast appears one cycle later.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   req        : per-source request (bit i = source i holds a valid result)
//   tag_in     : per-source producer label, slice i at [i*TAG_W +: TAG_W]
//   reg_in     : per-source destination register, sliced like tag_in
//   data_in    : per-source result data, sliced like tag_in
//   grant      : combinational one-hot grant, zero when idle or in reset
//   cdb_valid  : registered, high for one cycle per broadcast
//   cdb_src    : registered index of the broadcasting source
//   cdb_tag    : registered broadcast producer label
//   cdb_reg    : registered broadcast destination register
//   cdb_data   : registered broadcast data
module cdb_arbiter #(
    parameter int N_SRC   = 3,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int REG_W   = 3,
    parameter int RR_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            req,
    input  logic [N_SRC*TAG_W-1:0]      tag_in,
    input  logic [N_SRC*REG_W-1:0]      reg_in,
    input  logic [N_SRC*DATA_W-1:0]     data_in,
    output logic [N_SRC-1:0]            grant,
    output logic                        cdb_valid,
    output logic [$clog2(N_SRC)-1:0]    cdb_src,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [REG_W-1:0]            cdb_reg,
    output logic [DATA_W-1:0]           cdb_data
);

    localparam int SRC_W = $clog2(N_SRC);

    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  gnt_idx;
    logic              gnt_any;
    int                cand;
    logic [TAG_W-1:0]  sel_tag;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [SRC_W-1:0]  ptr_next;

    // Search the requests starting at ptr (round-robin) or at 0 (fixed
    // priority), wrapping past the top index. The first hit wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        if (!rst) begin
            for (int k = 0; k < N_SRC; k++) begin
                cand = (RR_MODE != 0) ? int'(ptr) + k : k;
                if (cand >= N_SRC) begin
                    cand = cand - N_SRC;
                end
                if (!gnt_any && req[SRC_W'(cand)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SRC_W'(cand);
                end
            end
            if (gnt_any) begin
                grant[gnt_idx] = 1'b1;
            end
        end
    end

    // Payload selection for the granted source.
    always_comb begin
        sel_tag  = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                sel_tag  = tag_in[i*TAG_W +: TAG_W];
                sel_reg  = reg_in[i*REG_W +: REG_W];
                sel_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap because N_SRC
    // need not be a power of two.
    assign ptr_next = (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    // Broadcast register. Payload holds its last value when idle so
    // consumers can still observe the most recent result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
            cdb_tag   <= '0;
            cdb_reg   <= '0;
            cdb_data  <= '0;
            ptr       <= '0;
        end else if (gnt_any) begin
            cdb_valid <= 1'b1;
            cdb_src   <= gnt_idx;
            cdb_tag   <= sel_tag;
            cdb_reg   <= sel_reg;
            cdb_data  <= sel_data;
            ptr       <= ptr_next;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule
